mem_dat_sized: RTL and testbench

Parametrised byte-addressed data memory for the MEM stage of the pipelined RISC-V core. Supports byte/half/word loads and stores with big-endian byte order, sign or zero extension, registered 1-cycle read, and alignment/range error detection. An optional reset-time clear sweep zeroes the array, with a `ready` output gating requests.

---
 rtl/mem_dat_sized.sv | 160 ++++++++++++++++
 tb/tb_mem_dat_sized.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dat_sized.sv
// Byte-addressed big-endian data memory for the MEM stage: byte/half/word access, 1-cycle registered load.
// Optional reset-time clear sweep enabled by defining MEM_DAT_SIZED_CLEAR_EN.
module mem_dat_sized #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] value,
   input  logic        esc_mem,
   input  logic        read_mem,
   input  logic [31:0] dst_mem,
   input  logic [1:0]  size,
   input  logic        unsigned_ld,
   output logic        ready,
   output logic [31:0] out_dat,
   output logic        out_valid,
   output logic        mis_err
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CNT_W = (ADDR_WIDTH > 2) ? ADDR_WIDTH - 2 : 1;

   logic [7:0]            mem_q [DEPTH];
   logic [31:0]           out_dat_q, out_dat_d;
   logic                  out_valid_q, out_valid_d;
   logic                  mis_err_q, mis_err_d;

   logic [ADDR_WIDTH-1:0] addr;
   logic                  in_range, legal, accept;
   logic                  do_store, do_load, do_err;
   logic                  clearing;
   logic [ADDR_WIDTH-1:0] clr_base;

   logic [3:0]            lane_en;
   logic [ADDR_WIDTH-1:0] lane_addr [4];
   logic [7:0]            lane_data [4];
   logic [7:0]            rd_byte   [4];
   logic [31:0]           load_data;

`ifdef MEM_DAT_SIZED_CLEAR_EN
   typedef enum logic {ST_CLEAR, ST_READY} state_e;

   state_e           state_q;
   logic [CNT_W-1:0] clr_cnt_q;
   logic             ready_q;

   // The sweep zeroes one word per cycle; ready rises on the edge that clears the last word.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
         ready_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               clr_cnt_q <= clr_cnt_q + 1'b1;
               if (clr_cnt_q == CNT_W'(DEPTH / 4 - 1)) begin
                  state_q <= ST_READY;
                  ready_q <= 1'b1;
               end
            end
            ST_READY: ready_q <= 1'b1;
         endcase
      end
   end

   assign ready    = ready_q;
   assign clearing = (state_q == ST_CLEAR) && !reset;
   assign clr_base = ADDR_WIDTH'({clr_cnt_q, 2'b00});
`else
   assign ready    = 1'b1;
   assign clearing = 1'b0;
   assign clr_base = '0;
`endif

   assign addr     = dst_mem[ADDR_WIDTH-1:0];
   assign in_range = (dst_mem >> ADDR_WIDTH) == 32'd0;
   assign accept   = ready && !reset;

   always_comb begin
      case (size)
         2'b00:   legal = in_range;
         2'b01:   legal = in_range && !dst_mem[0];
         2'b10:   legal = in_range && (dst_mem[1:0] == 2'b00);
         default: legal = 1'b0;
      endcase
   end

   // A simultaneous store and load performs only the store.
   assign do_store = accept && esc_mem && legal;
   assign do_load  = accept && read_mem && !esc_mem && legal;
   assign do_err   = accept && (esc_mem || read_mem) && !legal;

   // NOTE: every signal driven in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      lane_en = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         lane_addr[k] = addr + ADDR_WIDTH'(k);
         lane_data[k] = 8'h00;
      end
      if (clearing) begin
         lane_en = 4'b1111;
         for (int k = 0; k < 4; k++) lane_addr[k] = clr_base + ADDR_WIDTH'(k);
      end else if (do_store) begin
         case (size)
            2'b00: begin
               lane_en      = 4'b0001;
               lane_data[0] = value[7:0];
            end
            2'b01: begin
               lane_en      = 4'b0011;
               lane_data[0] = value[15:8];
               lane_data[1] = value[7:0];
            end
            default: begin
               lane_en = 4'b1111;
               for (int k = 0; k < 4; k++) lane_data[k] = value[31-8*k -: 8];
            end
         endcase
      end
   end

   // NOTE: the array itself has no reset; only the optional sweep clears it.
   always_ff @(posedge clock) begin
      for (int k = 0; k < 4; k++) begin
         if (lane_en[k]) mem_q[lane_addr[k]] <= lane_data[k];
      end
   end

   always_comb begin
      for (int k = 0; k < 4; k++) rd_byte[k] = mem_q[addr + ADDR_WIDTH'(k)];
      case (size)
         2'b00:   load_data = {{24{!unsigned_ld && rd_byte[0][7]}}, rd_byte[0]};
         2'b01:   load_data = {{16{!unsigned_ld && rd_byte[0][7]}}, rd_byte[0], rd_byte[1]};
         default: load_data = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
      endcase
   end

   assign out_valid_d = do_load;
   assign mis_err_d   = do_err;
   assign out_dat_d   = do_load ? load_data : out_dat_q;

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_dat_q   <= 32'h0;
         out_valid_q <= 1'b0;
         mis_err_q   <= 1'b0;
      end else begin
         out_dat_q   <= out_dat_d;
         out_valid_q <= out_valid_d;
         mis_err_q   <= mis_err_d;
      end
   end

   assign out_dat   = out_dat_q;
   assign out_valid = out_valid_q;
   assign mis_err   = mis_err_q;

endmodule

// File: tb/tb_mem_dat_sized.sv
// Scoreboard bench for mem_dat_sized: byte-array reference model, directed cases plus random traffic.
// Builds with or without MEM_DAT_SIZED_CLEAR_EN.
module tb_mem_dat_sized;

   localparam int AW    = 8;
   localparam int DEPTH = 2 ** AW;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] value;
   logic        esc_mem;
   logic        read_mem;
   logic [31:0] dst_mem;
   logic [1:0]  size;
   logic        unsigned_ld;
   logic        ready;
   logic [31:0] out_dat;
   logic        out_valid;
   logic        mis_err;

   mem_dat_sized #(.ADDR_WIDTH(AW)) dut (
      .clock(clock), .reset(reset), .value(value), .esc_mem(esc_mem),
      .read_mem(read_mem), .dst_mem(dst_mem), .size(size), .unsigned_ld(unsigned_ld),
      .ready(ready), .out_dat(out_dat), .out_valid(out_valid), .mis_err(mis_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      int unsigned tag;
      bit          is_err;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   int          tests = 0;
   int          fails = 0;
   int unsigned cyc   = 0;
   logic [7:0]  model_mem [DEPTH];
   logic [31:0] last_dat = 32'h0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: each pulse pops one expected response; an overdue entry is a missing response.
   always @(negedge clock) begin : monitor
      exp_t e;
      if (out_valid || mis_err) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pulse: out_valid=%0b mis_err=%0b at cycle %0d, none expected",
                     out_valid, mis_err, cyc);
         end else begin
            e = exp_q.pop_front();
            check("resp_cycle", 32'(cyc), 32'(e.tag));
            check("out_valid", 32'(out_valid), 32'(!e.is_err));
            check("mis_err", 32'(mis_err), 32'(e.is_err));
            check("out_dat", out_dat, e.data);
         end
      end else if (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
         e = exp_q.pop_front();
         tests++;
         fails++;
         $display("FAIL missing_response: no pulse at cycle %0d, expected %s with out_dat 0x%08h",
                  cyc, e.is_err ? "mis_err" : "out_valid", e.data);
      end
   end

   function automatic int nbytes(input logic [1:0] s);
      return 1 << s;
   endfunction

   function automatic bit model_legal(input logic [31:0] a, input logic [1:0] s);
      if (s == 2'b11) return 1'b0;
      if (a >= 32'(DEPTH)) return 1'b0;
      return (a % 32'(nbytes(s))) == 0;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s, input bit uns);
      logic [31:0] v;
      int n;
      n = nbytes(s);
      v = 32'h0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(model_mem[int'(a) + i]);
      if (n < 4 && !uns && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      return v;
   endfunction

   task automatic zero_inputs();
      esc_mem = 1'b0; read_mem = 1'b0; dst_mem = 32'h0;
      size = 2'b00; unsigned_ld = 1'b0; value = 32'h0;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      zero_inputs();
      repeat (n) step();
   endtask

   // Drive one request for one edge and record what the specification says must come back.
   task automatic issue(input bit st, input bit ld, input logic [31:0] a, input logic [1:0] s,
                        input bit uns, input logic [31:0] val, input bit accepted);
      int n;
      esc_mem = st; read_mem = ld; dst_mem = a; size = s; unsigned_ld = uns; value = val;
      if (accepted && (st || ld)) begin
         if (!model_legal(a, s)) begin
            exp_q.push_back('{tag: cyc + 1, is_err: 1'b1, data: last_dat});
         end else if (st) begin
            n = nbytes(s);
            for (int i = 0; i < n; i++) model_mem[int'(a) + i] = 8'(val >> (8 * (n - 1 - i)));
         end else begin
            last_dat = model_load(a, s, uns);
            exp_q.push_back('{tag: cyc + 1, is_err: 1'b0, data: last_dat});
         end
      end
      step();
   endtask

`ifdef MEM_DAT_SIZED_CLEAR_EN
   localparam logic EXP_READY_RST = 1'b0;

   // Counts cycles until ready; optionally attempts a word store while ready is still low.
   task automatic wait_ready(output int n, input int gate_at);
      n = 0;
      while (ready !== 1'b1 && n < 300) begin
         if (n == gate_at) begin
            esc_mem = 1'b1; dst_mem = 32'h60; size = 2'b10; value = 32'hDEADBEEF;
         end else begin
            zero_inputs();
         end
         step();
         n++;
      end
      zero_inputs();
   endtask
`else
   localparam logic EXP_READY_RST = 1'b1;
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      bit st, ld, uns;
      logic [1:0] s;
      logic [31:0] a;
      int r;

      for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
      zero_inputs();
      reset = 1'b1;
      step();
      step();
      check("rst_out_dat", out_dat, 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_mis_err", 32'(mis_err), 32'h0);
      check("rst_ready", 32'(ready), 32'(EXP_READY_RST));

`ifdef MEM_DAT_SIZED_CLEAR_EN
      reset = 1'b0;
      wait_ready(n, -1);
      check("sweep_len", 32'(n), 32'd64);
      reset = 1'b0;
      repeat (30) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      wait_ready(n, 10);
      check("sweep_len_restart", 32'(n), 32'd64);
      issue(0, 1, 32'hFC, 2'b10, 0, 0, 1);
      issue(0, 1, 32'h60, 2'b10, 0, 0, 1);
`else
      reset = 1'b0;
      // Contents are undefined at power-up, so give every word a known value first.
      for (int w = 0; w < DEPTH / 4; w++) issue(1, 0, 32'(4 * w), 2'b10, 0, 32'h0, 1);
`endif
      idle(2);

      issue(1, 0, 32'h10, 2'b10, 0, 32'h12345678, 1);
      issue(0, 1, 32'h10, 2'b00, 0, 0, 1);
      issue(0, 1, 32'h13, 2'b00, 0, 0, 1);
      issue(1, 0, 32'h21, 2'b00, 0, 32'hFFFFFF80, 1);
      issue(0, 1, 32'h21, 2'b00, 0, 0, 1);
      issue(0, 1, 32'h21, 2'b00, 1, 0, 1);
      issue(1, 0, 32'h22, 2'b01, 0, 32'h00008001, 1);
      issue(0, 1, 32'h22, 2'b01, 0, 0, 1);
      issue(0, 1, 32'h22, 2'b01, 1, 0, 1);
      issue(1, 0, 32'h30, 2'b10, 0, 32'hAABBCCDD, 1);
      issue(1, 0, 32'h32, 2'b00, 0, 32'h00000011, 1);
      issue(0, 1, 32'h30, 2'b10, 1, 0, 1);
      issue(0, 1, 32'h31, 2'b10, 0, 0, 1);
      issue(1, 0, 32'h41, 2'b01, 0, 32'h0000BEEF, 1);
      issue(0, 1, 32'h40, 2'b11, 0, 0, 1);
      issue(1, 0, 32'h40, 2'b11, 0, 32'h55555555, 1);
      issue(0, 1, 32'h100, 2'b10, 0, 0, 1);
      issue(1, 0, 32'h100, 2'b00, 0, 32'h000000AA, 1);
      issue(0, 1, 32'h40, 2'b10, 0, 0, 1);
      issue(0, 1, 32'h00, 2'b00, 0, 0, 1);
      issue(1, 1, 32'h50, 2'b10, 0, 32'hCAFEF00D, 1);
      issue(0, 1, 32'h50, 2'b10, 0, 0, 1);
      issue(0, 1, 32'h52, 2'b01, 0, 0, 1);
      idle(3);

      for (int it = 0; it < 600; it++) begin
         r   = $urandom_range(0, 9);
         st  = (r < 4);
         ld  = (r >= 3 && r < 9);
         s   = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         a   = 32'h80 + 32'($urandom_range(0, 63));
         if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(s) - 1);
         if ($urandom_range(0, 19) == 0) a = a | (32'h100 << $urandom_range(0, 23));
         uns = bit'($urandom_range(0, 1));
         issue(st, ld, a, s, uns, $urandom, 1);
      end
      idle(3);

      // A load sampled together with reset is discarded and out_dat returns to 0.
      issue(0, 1, 32'h10, 2'b10, 0, 0, 1);
      reset = 1'b1;
      issue(0, 1, 32'h30, 2'b10, 0, 0, 0);
      exp_q.delete();
      last_dat = 32'h0;
      check("midop_rst_out_valid", 32'(out_valid), 32'h0);
      check("midop_rst_out_dat", out_dat, 32'h0);
      reset = 1'b0;
`ifdef MEM_DAT_SIZED_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
      wait_ready(n, -1);
      check("sweep_len_again", 32'(n), 32'd64);
`endif
      issue(0, 1, 32'h10, 2'b10, 0, 0, 1);
      issue(0, 1, 32'h30, 2'b10, 0, 0, 1);
      idle(4);
      check("queue_drained", 32'(exp_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
